// File: rtl/mux_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4:1 word multiplexer.
// Drives the mux select, captures the word and hands it downstream over valid/ready.
module mux_arbiter #(
  parameter int WORD_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  output logic [1:0]            mux_sel,
  input  logic [WORD_WIDTH-1:0] mux_data,
  output logic [3:0]            ack,
  output logic [1:0]            grant_id,
  output logic                  busy,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SEND
  } state_t;

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  state_t                  state, state_next;
  logic [1:0]              last_grant, last_grant_next;
  logic [1:0]              mux_sel_next, grant_id_next;
  logic [3:0]              ack_next;
  logic [7:0]              burst_cnt, burst_cnt_next;
  logic [WORD_WIDTH-1:0]   out_data_next;
  logic                    out_valid_next;

  logic [1:0]              rr_idx;
  logic [1:0]              rr_cand;
  logic                    rr_found;

  // Cyclic search from last_grant+1; the fourth candidate wraps back to last_grant itself.
  always_comb begin
    rr_idx   = last_grant;
    rr_cand  = last_grant;
    rr_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      rr_cand = last_grant + 2'(k);
      if (!rr_found && req[rr_cand]) begin
        rr_idx   = rr_cand;
        rr_found = 1'b1;
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_next      = state;
    mux_sel_next    = mux_sel;
    grant_id_next   = grant_id;
    last_grant_next = last_grant;
    burst_cnt_next  = burst_cnt;
    out_data_next   = out_data;
    out_valid_next  = out_valid;
    ack_next        = '0;

    unique case (state)
      IDLE: begin
        if (rr_found) begin
          mux_sel_next  = rr_idx;
          grant_id_next = rr_idx;
          state_next    = CAPTURE;
        end
      end

      CAPTURE: begin
        out_data_next  = mux_data;
        out_valid_next = 1'b1;
        ack_next       = 4'b0001 << grant_id;
        burst_cnt_next = burst_cnt + 8'd1;
        state_next     = SEND;
      end

      SEND: begin
        if (out_valid && out_ready) begin
          out_valid_next = 1'b0;
          // mux_sel is left untouched so the next word of the burst is already selected.
          if (req[grant_id] && (burst_cnt < MAX_BURST_C)) begin
            state_next = CAPTURE;
          end else begin
            last_grant_next = grant_id;
            burst_cnt_next  = '0;
            state_next      = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mux_sel    <= '0;
      grant_id   <= '0;
      last_grant <= 2'd3;
      burst_cnt  <= '0;
      ack        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_next;
      mux_sel    <= mux_sel_next;
      grant_id   <= grant_id_next;
      last_grant <= last_grant_next;
      burst_cnt  <= burst_cnt_next;
      ack        <= ack_next;
      out_data   <= out_data_next;
      out_valid  <= out_valid_next;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: one instance with pure round robin, one with 4-word bursts.
// Both share stimulus; each test checks only the instance it targets.
module tb_mux_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic        out_ready;
  logic [15:0] in_word [4];

  logic [1:0]  mux_sel_rr, grant_id_rr, mux_sel_bu, grant_id_bu;
  logic [15:0] mux_data_rr, mux_data_bu, out_data_rr, out_data_bu;
  logic [3:0]  ack_rr, ack_bu;
  logic        busy_rr, busy_bu, out_valid_rr, out_valid_bu;

  int checks = 0;
  int errors = 0;

  assign mux_data_rr = in_word[mux_sel_rr];
  assign mux_data_bu = in_word[mux_sel_bu];

  mux_arbiter #(.WORD_WIDTH(16), .MAX_BURST(1)) dut_rr (
    .clk(clk), .rst(rst), .req(req), .mux_sel(mux_sel_rr), .mux_data(mux_data_rr),
    .ack(ack_rr), .grant_id(grant_id_rr), .busy(busy_rr), .out_data(out_data_rr),
    .out_valid(out_valid_rr), .out_ready(out_ready)
  );

  mux_arbiter #(.WORD_WIDTH(16), .MAX_BURST(4)) dut_bu (
    .clk(clk), .rst(rst), .req(req), .mux_sel(mux_sel_bu), .mux_data(mux_data_bu),
    .ack(ack_bu), .grant_id(grant_id_bu), .busy(busy_bu), .out_data(out_data_bu),
    .out_valid(out_valid_bu), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    out_ready = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b0000;
    out_ready = 1'b0;
    tick(2);
    checks++;
    if ({mux_sel_bu, grant_id_bu, ack_bu, out_valid_bu, busy_bu} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got sel=%0d gid=%0d ack=%b vld=%b busy=%b, expected all 0",
               mux_sel_bu, grant_id_bu, ack_bu, out_valid_bu, busy_bu);
    end
    checks++;
    if (out_data_bu !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0000", out_data_bu);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_single();
    do_reset();
    in_word[2] = 16'hBEEF;
    req = 4'b0100;
    out_ready = 1'b1;
    tick(1);
    checks++;
    if (mux_sel_bu !== 2'd2 || busy_bu !== 1'b1) begin
      errors++;
      $display("FAIL single_sel: got sel=%0d busy=%b expected sel=2 busy=1", mux_sel_bu, busy_bu);
    end
    tick(1);
    req = 4'b0000;
    checks++;
    if (out_valid_bu !== 1'b1 || out_data_bu !== 16'hBEEF || ack_bu !== 4'b0100) begin
      errors++;
      $display("FAIL single_word: got vld=%b data=%h ack=%b expected 1 BEEF 0100",
               out_valid_bu, out_data_bu, ack_bu);
    end
    tick(1);
    checks++;
    if (out_valid_bu !== 1'b0 || busy_bu !== 1'b0 || ack_bu !== 4'b0000 || out_data_bu !== 16'hBEEF) begin
      errors++;
      $display("FAIL single_done: got vld=%b busy=%b ack=%b data=%h expected 0 0 0000 BEEF",
               out_valid_bu, busy_bu, ack_bu, out_data_bu);
    end
  endtask

  task automatic test_round_robin();
    int exp_id [5];
    logic [3:0] exp_ack;
    int n;
    exp_id = '{0, 1, 2, 3, 0};
    n = 0;
    do_reset();
    req = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && n < 5; c++) begin
      tick(1);
      if (ack_rr !== 4'b0000) begin
        exp_ack = 4'b0001 << exp_id[n];
        checks++;
        if (ack_rr !== exp_ack || grant_id_rr !== 2'(exp_id[n])) begin
          errors++;
          $display("FAIL rr_order[%0d]: got ack=%b gid=%0d expected ack=%b gid=%0d",
                   n, ack_rr, grant_id_rr, exp_ack, exp_id[n]);
        end
        n++;
      end
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL rr_timeout: got %0d grants expected 5", n);
    end
    req = 4'b0000;
    tick(4);
  endtask

  task automatic test_burst();
    int          exp_id   [5];
    logic [15:0] exp_data [5];
    int          exp_gap  [5];
    int          last_c;
    int          n;
    exp_id   = '{0, 0, 0, 0, 1};
    exp_data = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'hA001};
    exp_gap  = '{0, 2, 2, 2, 3};
    n = 0;
    last_c = 0;
    do_reset();
    in_word[0] = 16'h0100;
    in_word[1] = 16'hA001;
    req = 4'b0011;
    out_ready = 1'b1;
    for (int c = 0; c < 60 && n < 5; c++) begin
      tick(1);
      if (ack_bu !== 4'b0000) begin
        checks++;
        if (grant_id_bu !== 2'(exp_id[n]) || out_data_bu !== exp_data[n] || out_valid_bu !== 1'b1) begin
          errors++;
          $display("FAIL burst_word[%0d]: got gid=%0d data=%h vld=%b expected gid=%0d data=%h vld=1",
                   n, grant_id_bu, out_data_bu, out_valid_bu, exp_id[n], exp_data[n]);
        end
        if (n > 0) begin
          checks++;
          if (c - last_c != exp_gap[n]) begin
            errors++;
            $display("FAIL burst_gap[%0d]: got %0d cycles expected %0d", n, c - last_c, exp_gap[n]);
          end
        end
        if (ack_bu[0]) in_word[0] = in_word[0] + 16'd1;
        last_c = c;
        n++;
        if (n == 5) req = 4'b0000;
      end
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL burst_timeout: got %0d words expected 5", n);
    end
    tick(4);
  endtask

  task automatic test_backpressure();
    int extra;
    do_reset();
    in_word[1] = 16'h1234;
    req = 4'b0010;
    out_ready = 1'b0;
    tick(2);
    req = 4'b0000;
    checks++;
    if (out_valid_bu !== 1'b1 || out_data_bu !== 16'h1234 || ack_bu !== 4'b0010) begin
      errors++;
      $display("FAIL bp_capture: got vld=%b data=%h ack=%b expected 1 1234 0010",
               out_valid_bu, out_data_bu, ack_bu);
    end
    in_word[1] = 16'h5555;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++;
      if (out_valid_bu !== 1'b1 || out_data_bu !== 16'h1234 || mux_sel_bu !== 2'd1 || ack_bu !== 4'b0000) begin
        errors++;
        $display("FAIL bp_stall[%0d]: got vld=%b data=%h sel=%0d ack=%b expected 1 1234 1 0000",
                 i, out_valid_bu, out_data_bu, mux_sel_bu, ack_bu);
      end
    end
    out_ready = 1'b1;
    tick(1);
    checks++;
    if (out_valid_bu !== 1'b0 || busy_bu !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got vld=%b busy=%b expected 0 0", out_valid_bu, busy_bu);
    end
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (out_valid_bu === 1'b1 || ack_bu !== 4'b0000) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL bp_duplicate: got %0d extra valid/ack cycles expected 0", extra);
    end
  endtask

  task automatic test_drop_burst();
    do_reset();
    in_word[3] = 16'h3333;
    in_word[0] = 16'h0A0A;
    req = 4'b1000;
    out_ready = 1'b1;
    tick(2);
    checks++;
    if (ack_bu !== 4'b1000 || out_data_bu !== 16'h3333) begin
      errors++;
      $display("FAIL drop_word: got ack=%b data=%h expected 1000 3333", ack_bu, out_data_bu);
    end
    req = 4'b0101;
    tick(1);
    checks++;
    if (busy_bu !== 1'b0 || out_valid_bu !== 1'b0) begin
      errors++;
      $display("FAIL drop_end: got busy=%b vld=%b expected 0 0", busy_bu, out_valid_bu);
    end
    tick(1);
    checks++;
    if (mux_sel_bu !== 2'd0 || grant_id_bu !== 2'd0) begin
      errors++;
      $display("FAIL drop_next_grant: got sel=%0d gid=%0d expected 0 0", mux_sel_bu, grant_id_bu);
    end
    req = 4'b0000;
    tick(1);
    checks++;
    if (ack_bu !== 4'b0001 || out_data_bu !== 16'h0A0A) begin
      errors++;
      $display("FAIL drop_next_word: got ack=%b data=%h expected 0001 0A0A", ack_bu, out_data_bu);
    end
    tick(3);
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_word[2] = 16'h7777;
    in_word[0] = 16'h0F0F;
    req = 4'b0100;
    out_ready = 1'b0;
    tick(2);
    checks++;
    if (out_valid_bu !== 1'b1 || mux_sel_bu !== 2'd2) begin
      errors++;
      $display("FAIL rstmid_pre: got vld=%b sel=%0d expected 1 2", out_valid_bu, mux_sel_bu);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid_bu !== 1'b0 || ack_bu !== 4'b0000 || mux_sel_bu !== 2'd0 || busy_bu !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: got vld=%b ack=%b sel=%0d busy=%b expected 0 0000 0 0",
               out_valid_bu, ack_bu, mux_sel_bu, busy_bu);
    end
    req = 4'b1111;
    rst = 1'b0;
    tick(1);
    checks++;
    if (mux_sel_bu !== 2'd0 || grant_id_bu !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_restart: got sel=%0d gid=%0d expected 0 0", mux_sel_bu, grant_id_bu);
    end
    req = 4'b0000;
    out_ready = 1'b1;
    tick(1);
    checks++;
    if (ack_bu !== 4'b0001 || out_data_bu !== 16'h0F0F) begin
      errors++;
      $display("FAIL rstmid_word: got ack=%b data=%h expected 0001 0F0F", ack_bu, out_data_bu);
    end
    tick(3);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) in_word[i] = 16'h0000;
    rst = 1'b0;
    req = 4'b0000;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_backpressure();
    test_drop_burst();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
